// File: rtl/pixel_sum_sequencer.sv
// Feeds signed pixel products (or saturated 8-beat row sums) to a 4-lane accumulator, lanes 3..0.
// Optional feature macro: ROW_SUM_EN (row summing with 16-bit saturation).
module pixel_sum_sequencer #(
    parameter int DW = 32,
    parameter int PW = 8
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                start,
    input  logic [PW-1:0]       pix_a,
    input  logic [PW-1:0]       pix_b,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [1:0]          ww,
    output logic [2*DW+1:0]     Sum,
    output logic                busy,
    output logic                done
);

    localparam int SW  = 2*DW + 2;
    localparam int PRW = 2*PW;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t          state_q;
    logic [7:0]      cnt_q;
    logic            flush_q;
    logic [1:0]      ww_q;
    logic [SW-1:0]   sum_q;
    logic            in_ready_q;
    logic            busy_q;
    logic            done_q;

    logic signed [PW-1:0]  a_s;
    logic signed [PW-1:0]  b_s;
    logic signed [PRW-1:0] prod_s;
    logic                  accept_s;
    logic                  issue_en_s;
    logic [PRW-1:0]        issue_s;

    assign a_s      = pix_a;
    assign b_s      = pix_b;
    assign prod_s   = a_s * b_s;
    assign accept_s = in_valid && in_ready_q && (state_q == S_RUN);

`ifdef ROW_SUM_EN
    logic signed [PRW+2:0] row_q;
    logic signed [PRW+2:0] row_next_s;

    function automatic logic [PRW-1:0] sat_row(input logic signed [PRW+2:0] v);
        logic signed [PRW+2:0] hi;
        logic signed [PRW+2:0] lo;
        hi = {4'b0000, {(PRW-1){1'b1}}};
        lo = {4'b1111, {(PRW-1){1'b0}}};
        if (v > hi) begin
            return {1'b0, {(PRW-1){1'b1}}};
        end else if (v < lo) begin
            return {1'b1, {(PRW-1){1'b0}}};
        end else begin
            return v[PRW-1:0];
        end
    endfunction

    assign row_next_s = row_q + {{3{prod_s[PRW-1]}}, prod_s};

    // Issue only on the eighth beat of each row.
    always_comb begin
        issue_en_s = 1'b0;
        issue_s    = {PRW{1'b0}};
        if (accept_s && (cnt_q[2:0] == 3'd7)) begin
            issue_en_s = 1'b1;
            issue_s    = sat_row(row_next_s);
        end else begin
            issue_en_s = 1'b0;
        end
    end

    // Row accumulator clears after each issue and whenever a frame starts.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            row_q <= '0;
        end else if (state_q == S_IDLE) begin
            row_q <= '0;
        end else if (accept_s) begin
            row_q <= (cnt_q[2:0] == 3'd7) ? '0 : row_next_s;
        end else begin
            row_q <= row_q;
        end
    end
`else
    // Every accepted beat issues its product directly.
    always_comb begin
        issue_en_s = 1'b0;
        issue_s    = {PRW{1'b0}};
        if (accept_s) begin
            issue_en_s = 1'b1;
            issue_s    = prod_s;
        end else begin
            issue_en_s = 1'b0;
        end
    end
`endif

    // Frame sequencer with registered accumulator-facing outputs.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= 8'd0;
            flush_q    <= 1'b0;
            ww_q       <= 2'b11;
            sum_q      <= {SW{1'b0}};
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    sum_q      <= {SW{1'b0}};
                    in_ready_q <= 1'b0;
                    done_q     <= 1'b0;
                    if (start) begin
                        state_q    <= S_RUN;
                        cnt_q      <= 8'd0;
                        busy_q     <= 1'b1;
                        in_ready_q <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (accept_s) begin
                        ww_q  <= 2'd3 - cnt_q[7:6];
                        cnt_q <= cnt_q + 8'd1;
                        sum_q <= issue_en_s ? {{(SW-PRW){issue_s[PRW-1]}}, issue_s} : {SW{1'b0}};
                        if (cnt_q == 8'd255) begin
                            state_q    <= S_FLUSH;
                            in_ready_q <= 1'b0;
                            flush_q    <= 1'b0;
                        end
                    end else begin
                        sum_q <= {SW{1'b0}};
                    end
                end
                S_FLUSH: begin
                    // Two quiet cycles let the accumulator's register stage drain.
                    sum_q <= {SW{1'b0}};
                    ww_q  <= 2'b00;
                    if (flush_q) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        flush_q <= 1'b1;
                    end
                end
                S_DONE: begin
                    sum_q   <= {SW{1'b0}};
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q    <= S_IDLE;
                    sum_q      <= {SW{1'b0}};
                    in_ready_q <= 1'b0;
                    busy_q     <= 1'b0;
                    done_q     <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready = in_ready_q;
    assign ww       = ww_q;
    assign Sum      = sum_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_pixel_sum_sequencer.sv
// Scoreboard bench for pixel_sum_sequencer: driver queues expected issues, monitor compares.
module tb_pixel_sum_sequencer;

    localparam int DW = 32;
    localparam int PW = 8;
    localparam int SW = 2*DW + 2;

    logic          clk = 1'b0;
    logic          n_rst = 1'b0;
    logic          start = 1'b0;
    logic [PW-1:0] pix_a = '0;
    logic [PW-1:0] pix_b = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [1:0]    ww;
    logic [SW-1:0] Sum;
    logic          busy;
    logic          done;

    pixel_sum_sequencer #(.DW(DW), .PW(PW)) dut (
        .clk(clk), .n_rst(n_rst), .start(start), .pix_a(pix_a), .pix_b(pix_b),
        .in_valid(in_valid), .in_ready(in_ready), .ww(ww), .Sum(Sum),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]    ww;
        logic [SW-1:0] sum;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;
    int   done_cnt = 0;
    int   nz_cnt = 0;
    int   frames_done = 0;
    logic acc_prev = 1'b0;

    task automatic chk(input string nm, input logic [SW-1:0] act, input logic [SW-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    function automatic void pix(input int kind, input int idx,
                                output logic signed [7:0] a, output logic signed [7:0] b);
        case (kind)
            0:       begin a = 8'(idx - 20); b = 8'sd7; end
            1:       begin a = 8'sd1; b = 8'sd1; end
            2:       begin a = -8'sd128; b = (idx % 2 == 0) ? 8'sd127 : -8'sd128; end
            3:       begin a = 8'sd3; b = -8'sd5; end
            default: begin a = -8'sd128; b = -8'sd128; end
        endcase
    endfunction

    // Acceptance as seen at each rising edge.
    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) acc_prev <= 1'b0;
        else        acc_prev <= in_valid && in_ready;
    end

    // Monitor: pops one expectation per issued beat, checks quiet cycles otherwise.
    always @(negedge clk) begin
        exp_t e;
        if (n_rst) begin
            if (done) done_cnt++;
            if (Sum != '0) nz_cnt++;
            if (acc_prev) begin
                if (q.size() == 0) begin
                    chk("sb_underflow", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("sum", Sum, e.sum);
                    chk("ww", {64'd0, ww}, {64'd0, e.ww});
                end
            end else if (busy) begin
                chk("gap_sum", Sum, '0);
            end
        end
    end

    task automatic run_frame(input int kind, input bit toggle, input int stop_after, input int start_at);
        int beats = 0;
        int cyc = 0;
        int rdy_cyc = 0;
        int row = 0;
        int p;
        int v;
        int exp_nz = 0;
        int dk = 0;
        bit tog = 1'b0;
        bit vld;
        logic signed [7:0] a;
        logic signed [7:0] b;
        logic signed [SW-1:0] t;
        exp_t e;
        for (int i = 0; i < 256; i++) begin
            pix(kind, i, a, b);
            p = int'(a) * int'(b);
`ifdef ROW_SUM_EN
            row = row + p;
            if (i % 8 == 7) begin
                v = (row > 32767) ? 32767 : ((row < -32768) ? -32768 : row);
                row = 0;
            end else begin
                v = 0;
            end
`else
            v = p;
`endif
            if (v != 0) exp_nz++;
            t = SW'(signed'(v));
            e.sum = t;
            e.ww  = 2'(3 - i / 64);
            q.push_back(e);
        end
        nz_cnt = 0;
        @(negedge clk) start = 1'b1;
        while (beats < stop_after && cyc < 2000) begin
            @(negedge clk);
            start = (start_at > 0 && beats == start_at);
            cyc++;
            if (in_ready) rdy_cyc++;
            if (toggle) begin
                vld = tog;
                tog = ~tog;
            end else begin
                vld = 1'b1;
            end
            pix(kind, beats, a, b);
            pix_a = a;
            pix_b = b;
            in_valid = vld;
            if (vld && in_ready) beats++;
        end
        if (cyc >= 2000) chk("beat_timeout", 0, 1);
        if (stop_after < 256) return;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            in_valid = 1'b0;
            start = 1'b0;
            if (done) begin
                dk = k;
                break;
            end
        end
        chk("done_latency", dk, 3);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("done_one_cycle", {65'd0, done}, '0);
        @(negedge clk);
        chk("idle_busy", {65'd0, busy}, '0);
        chk("idle_ready", {65'd0, in_ready}, '0);
        frames_done++;
        chk("done_count", done_cnt, frames_done);
        chk("nonzero_issues", nz_cnt, exp_nz);
        chk("sb_empty", q.size(), 0);
        if (toggle) chk("run_cycles", rdy_cyc, 512);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_sum", Sum, '0);
        chk("rst_ww", {64'd0, ww}, {64'd0, 2'b11});
        chk("rst_busy_ready_done", {63'd0, busy, in_ready, done}, '0);
        n_rst = 1'b1;

        run_frame(0, 1'b0, 37, 0);
        @(negedge clk);
        in_valid = 1'b0;
        #2 n_rst = 1'b0;
        #1;
        chk("abort_sum", Sum, '0);
        chk("abort_ww", {64'd0, ww}, {64'd0, 2'b11});
        chk("abort_busy", {65'd0, busy}, '0);
        chk("abort_ready", {65'd0, in_ready}, '0);
        q.delete();
        @(negedge clk) n_rst = 1'b1;

        run_frame(1, 1'b0, 256, 0);
        run_frame(2, 1'b0, 256, 100);
        run_frame(3, 1'b1, 256, 0);
        run_frame(4, 1'b0, 256, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pixel_sum_sequencer.md
Name: pixel_sum_sequencer

Overview:
Upstream feeder for the 4-lane pixel accumulator. It consumes a stream of signed pixel pairs covering four 8x8 blocks (256 beats) and forms each product. It drives the accumulator's lane select `ww` and its `Sum` word, with lanes issued in order 3,2,1,0. Because the accumulator adds `Sum` on every clock, this block drives `Sum` to zero whenever no product is being issued.

Parameters:
- DW, 32, accumulator data width; the `Sum` port is 2*DW+2 bits.
- PW, 8, signed pixel width; the product is 2*PW = 16 bits.

Ports:
- clk  input  1  system clock, rising edge.
- n_rst  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request to begin a 256-beat frame; honoured only in IDLE.
- pix_a  input  PW  signed pixel operand A.
- pix_b  input  PW  signed pixel operand B (coefficient).
- in_valid  input  1  pixel pair valid.
- in_ready  output  1  block accepts a pair this cycle.
- ww  output  2  lane select to the accumulator.
- Sum  output  2*DW+2  sign-extended product or row sum to the accumulator.
- busy  output  1  frame in progress.
- done  output  1  one-cycle pulse when the frame is complete and flushed.

Behaviour:
- Reset (async, n_rst=0): state=IDLE, Sum=0, ww=2'b11, in_ready=0, busy=0, done=0, beat counter=0.
- FSM states: IDLE, RUN, FLUSH, DONE.
- IDLE: in_ready=0, Sum=0. When start=1, go to RUN next cycle with counter=0 and busy=1.
- RUN: in_ready=1. A beat is accepted when in_valid&&in_ready.
  - Accepted beat: register Sum <= signed(pix_a)*signed(pix_b), sign-extended to 2*DW+2 bits. Register ww <= 3 - cnt[7:6]. Increment cnt.
  - No accepted beat: Sum <= 0, ww holds its value.
  - Latency from accepted beat to Sum/ww output: 1 cycle.
- When the beat with cnt=255 is accepted, go to FLUSH, cnt wraps to 0, and in_ready drops the next cycle.
- FLUSH: 2 cycles with Sum=0 and ww holding 2'b00, covering the accumulator's register stage. Then go to DONE.
- DONE: done=1 for exactly one cycle, busy drops to 0 the same cycle, then go to IDLE.
- start is ignored outside IDLE. start in the DONE cycle is also ignored.
- in_valid with in_ready=0 is dropped; upstream must hold the pair.
- Arithmetic: the product range is -16256..16384 and always fits 16 bits signed. No saturation in the default build.
- Reset asserted mid-frame aborts immediately and all outputs take their reset values. A partial frame is not resumed.

Optional Feature:
- Macro ROW_SUM_EN.
- Defined:
  - 8 consecutive products per row are summed in an internal 19-bit signed register.
  - Sum is issued only on the 8th beat of each row, 32 issues per frame, saturated to signed 16 bits: >32767 gives 32767, < -32768 gives -32768, then sign-extended.
  - Non-final beats drive Sum=0.
  - The row register clears after each issue and on reset.
- Undefined: one Sum per accepted beat as above.

Test Plan:
- Reset mid-RUN after 37 beats: Sum=0, ww=2'b11, busy=0, in_ready=0 asynchronously. The next start restarts at cnt=0.
- start, then 256 beats of pix_a=1, pix_b=1 with continuous in_valid: Sum[15:0]=1 per beat. ww=3 for beats 0-63, 2 for 64-127, 1 for 128-191, 0 for 192-255. done pulses 3 cycles after the last beat.
- pix_a=-128, pix_b=127: Sum[15:0]=16'hC080 and all upper bits 1. pix_a=-128, pix_b=-128: Sum=16384.
- in_valid toggled 1/0 each cycle: Sum=0 on gap cycles, frame completes after 512 RUN cycles, and exactly 256 nonzero Sum issues when all products are nonzero.
- start asserted during RUN and during DONE: no effect on cnt or ww. done asserts once per frame.
- ROW_SUM_EN, all pairs -128*-128: each row sum of 131072 saturates, giving Sum=32767 on every 8th beat and 0 otherwise, 8 issues per lane.
